// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module  : alu_pkg
// Brief   : Shared ALU types and constants (multiply sequencer states, ctrl bits)
// Revision: 1.0
// ============================================================================
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        BUSY  = 2'd2,
        DONE  = 2'd3
    } mseq_state_t;

    localparam int ALU_MULT_BIT  = 3;
    localparam int MULTI_DEFAULT = 8;

    // Counter width for a latency value; never narrower than one bit.
    function automatic int cnt_width(input int latency);
        return (latency > 1) ? $clog2(latency) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mseq_counter.sv
`default_nettype none
// ============================================================================
// Module  : mseq_counter
// Brief   : Loadable down-counter with zero flag for the multiply sequencer
// Revision: 1.0
// ============================================================================
module mseq_counter #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] i_load_val,
    input  logic         i_load,
    input  logic         i_dec,
    input  logic         i_clr,
    output logic         o_zero
);

    logic [W-1:0] cnt_d;
    logic [W-1:0] cnt_q;

    // Clear wins over load, load wins over decrement; decrement saturates at 0.
    always_comb begin
        cnt_d = cnt_q;
        if (i_clr) begin
            cnt_d = '0;
        end else if (i_load) begin
            cnt_d = i_load_val;
        end else if (i_dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_zero = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/alu_mult_seq.sv
`default_nettype none
// ============================================================================
// Module  : alu_mult_seq
// Brief   : EX-stage sequencer for the fixed-latency multiplier (start/stall/capture)
// Revision: 1.0
// ============================================================================
module alu_mult_seq
    import alu_pkg::*;
#(
    parameter int MULTI  = MULTI_DEFAULT,
    parameter int DATA_W = 32,
    parameter int PROD_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        alu_ctrl,
    input  logic              op_valid,
    input  logic              flush,
    input  logic [PROD_W-1:0] mult_out,
    output logic              mult_start,
    output logic              mult_clr,
    output logic              stall,
    output logic              busy,
    output logic [DATA_W-1:0] result,
    output logic              result_valid
);

    localparam int               c_cnt_w    = cnt_width(MULTI);
    localparam logic [c_cnt_w-1:0] c_cnt_load = c_cnt_w'(MULTI - 1);

    mseq_state_t       state_d;
    mseq_state_t       state_q;
    logic [PROD_W-1:0] prod_d;
    logic [PROD_W-1:0] prod_q;

    logic              w_req;
    logic              w_cnt_load;
    logic              w_cnt_dec;
    logic              w_cnt_clr;
    logic              w_cnt_zero;
    logic [PROD_W-1:0] w_res_narrow;
    logic              w_unused_ctrl;

    // Only the multiply-select bit of alu_ctrl matters to this block.
    assign w_unused_ctrl = ^(alu_ctrl & ~(4'b0001 << ALU_MULT_BIT));

    // Gating with rst keeps stall low while reset is held, even in IDLE.
    assign w_req = op_valid & alu_ctrl[ALU_MULT_BIT] & ~flush & rst;

    always_comb begin
        state_d    = state_q;
        prod_d     = prod_q;
        w_cnt_load = 1'b0;
        w_cnt_dec  = 1'b0;
        w_cnt_clr  = 1'b0;
        case (state_q)
            IDLE: begin
                if (w_req) begin
                    state_d = START;
                end
            end
            START: begin
                if (flush) begin
                    state_d   = IDLE;
                    w_cnt_clr = 1'b1;
                end else begin
                    state_d    = BUSY;
                    w_cnt_load = 1'b1;
                end
            end
            BUSY: begin
                if (flush) begin
                    state_d   = IDLE;
                    w_cnt_clr = 1'b1;
                end else if (w_cnt_zero) begin
                    state_d = DONE;
                end else begin
                    w_cnt_dec = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                if (flush) begin
                    w_cnt_clr = 1'b1;
                end else begin
                    prod_d = mult_out;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            prod_q  <= prod_d;
        end
    end

    mseq_counter #(
        .W (c_cnt_w)
    ) u_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_load_val (c_cnt_load),
        .i_load     (w_cnt_load),
        .i_dec      (w_cnt_dec),
        .i_clr      (w_cnt_clr),
        .o_zero     (w_cnt_zero)
    );

    // A flush in any active state turns the cycle into a clear pulse instead.
    assign busy         = (state_q != IDLE);
    assign mult_start   = (state_q == START) & ~flush;
    assign mult_clr     = (state_q != IDLE) & flush;
    assign result_valid = (state_q == DONE) & ~flush;
    assign stall        = (state_q == IDLE) ? w_req
                                            : ((state_q != DONE) & ~flush);

    // The DONE cycle forwards the live product so EX sees it as it advances.
    assign w_res_narrow = result_valid ? mult_out : prod_q;

    generate
        if (DATA_W > PROD_W) begin : g_res_pad
            assign result = {{(DATA_W - PROD_W){1'b0}}, w_res_narrow};
        end else begin : g_res_full
            assign result = w_res_narrow;
        end
    endgenerate

endmodule
`default_nettype wire

// File: doc/alu_mult_seq.md
# alu_mult_seq

Multicycle sequencer for the ALU's sequential multiplier path. It sits beside the ALU in the EX stage. When the EX instruction selects the multiply path (alu_ctrl[3] = 1), it:
- issues a one-cycle start pulse to the multiplier,
- counts the fixed multiplier latency while stalling the pipeline,
- captures the product and releases the stall for exactly one cycle.

It also aborts an in-flight multiply on pipeline flush.

## Interface
Parameters:
- MULTI, 8, multiplier latency in cycles after the start pulse (≥ 1)
- DATA_W, 32, ALU result width
- PROD_W, 8, multiplier product width (≤ DATA_W)

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- alu_ctrl  in  4  EX-stage ALU control; bit 3 selects multiply
- op_valid  in  1  EX stage holds a valid instruction
- flush  in  1  kill the current EX instruction
- mult_out  in  PROD_W  product from the multiplier
- mult_start  out  1  one-cycle start pulse to the multiplier
- mult_clr  out  1  one-cycle clear pulse to the multiplier on abort
- stall  out  1  hold IF/ID/EX pipeline registers
- busy  out  1  FSM not in IDLE
- result  out  DATA_W  captured product, zero-extended
- result_valid  out  1  result updated this cycle (one-cycle pulse)

## Operation
- State encoding: IDLE, START, BUSY, DONE. Down-counter cnt is $clog2(MULTI) bits wide, minimum 1.
- req = op_valid & alu_ctrl[3] & ~flush.
- IDLE:
  - stall = req (combinational).
  - req goes to START. Otherwise stay in IDLE.
  - Non-multiply ops never stall and never pulse result_valid.
- START:
  - mult_start = 1 and stall = 1.
  - cnt loaded with MULTI-1; next state is BUSY.
- BUSY:
  - stall = 1.
  - cnt == 0 goes to DONE. Otherwise cnt decrements.
  - BUSY lasts exactly MULTI cycles.
- DONE:
  - result <= {zeros, mult_out}; result_valid = 1; stall = 0 so the pipeline advances.
  - Next state is IDLE.
- alu_ctrl and op_valid are sampled only in IDLE; changes in other states are ignored.
- result holds its value until the next DONE capture.
- Flush in START, BUSY or DONE:
  - next state is IDLE; cnt cleared; mult_clr = 1 that cycle; stall = 0 that cycle.
  - In DONE, result and result_valid are suppressed; result keeps its old value.
- Flush in IDLE: no request is taken; mult_start never pulses.
- busy = (state != IDLE).

## Timing
- Reset values: state IDLE, cnt 0, result 0. mult_start, mult_clr, stall, busy and result_valid are all 0.
- Reset asserted mid-operation returns to IDLE immediately (asynchronous). No pulses are produced, and the multiplier is not cleared by this block.
- Request seen in cycle 0 gives:
  - mult_start in cycle 1,
  - BUSY in cycles 2..MULTI+1,
  - DONE in cycle MULTI+2.
- stall is high in cycles 0..MULTI+1, which is MULTI+2 cycles. For MULTI = 8, stall is high for 10 cycles and result_valid pulses in cycle 10.
- mult_out is sampled in the DONE cycle, MULTI+1 cycles after the start pulse.
- Back-to-back multiplies: the next instruction reaches EX in the cycle after DONE and is evaluated in IDLE. There is one idle cycle between operations and no re-trigger of the completed instruction.
- mult_start, mult_clr and result_valid are never high for two consecutive cycles. They are mutually exclusive within any cycle.

## Structure
- Shared package alu_pkg holds:
  - typedef enum logic [1:0] mseq_state_t {IDLE, START, BUSY, DONE},
  - localparam ALU_MULT_BIT = 3,
  - default MULTI.
- The ALU and the hazard unit import the same package.
- One natural sub-module: mseq_counter, a loadable down-counter with zero flag (inputs: load value, load, dec, clr).
- The FSM and result register stay in the top.

## Test plan
- alu_ctrl = 4'h2, op_valid = 1 for 5 cycles -> stall, mult_start and result_valid stay 0 throughout.
- alu_ctrl = 4'h8, op_valid = 1 in cycle 0, mult_out = 8'hA5 -> expect:
  - mult_start high in cycle 1 only,
  - stall high in cycles 0–9,
  - result_valid in cycle 10 with result = 32'h000000A5.
- Two consecutive multiplies (mult_out 8'h03 then 8'hFF) -> two result_valid pulses 11 cycles apart, with results 32'h3 then 32'hFF.
- Flush asserted in the 4th BUSY cycle -> mult_clr pulses once, stall drops that cycle, no result_valid, result unchanged, FSM returns to IDLE.
- rst driven low during BUSY, released 2 cycles later -> all outputs 0 asynchronously, result = 0. A new multiply then completes with normal MULTI+2 latency.
- Flush in the same cycle as a request in IDLE, and flush during DONE -> no start pulse in the first case, no result_valid in the second.
